// File: rtl/conv_mac_array_v2.sv
// ============================================================================
// Module   : conv_mac_array_v2
// Brief    : KPF x CPF multiply-accumulate array with bias, rounding requant,
//            optional ReLU, saturation and a 2-entry ready/valid output buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_mac_array_v2 #(
  parameter int CPF       = 4,
  parameter int KPF       = 8,
  parameter int DIN_DW    = 8,
  parameter int WW        = 8,
  parameter int BIAS_DW   = 8,
  parameter int BIAS_SHL  = 0,
  parameter int ACC_WIDTH = 32,
  parameter int DOUT_DW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 cfg_shift,
  input  logic                       cfg_relu,
  input  logic                       op_din_en,
  output logic                       op_din_rdy,
  input  logic                       op_din_eop,
  input  logic [CPF*DIN_DW-1:0]      op_din,
  input  logic [KPF*CPF*WW-1:0]      op_weight,
  input  logic [KPF*BIAS_DW-1:0]     op_bias,
  output logic                       blob_dout_en,
  input  logic                       blob_dout_rdy,
  output logic [KPF*DOUT_DW-1:0]     blob_dout
);

  localparam int c_PROD_W = DIN_DW + WW;
  localparam int c_NP     = KPF * CPF;
  localparam int c_V_W    = ACC_WIDTH + BIAS_SHL + 2;
  localparam logic signed [c_V_W-1:0] c_DOUT_MAX = c_V_W'((64'sd1 <<< (DOUT_DW - 1)) - 64'sd1);
  localparam logic signed [c_V_W-1:0] c_DOUT_MIN = c_V_W'(-(64'sd1 <<< (DOUT_DW - 1)));

  logic                          w_accept;
  logic                          w_push;
  logic                          w_pop;
  logic                          r_live;
  logic                          r_first;

  logic                          r_s1_v, r_s1_eop, r_s1_first, r_s1_relu;
  logic [KPF*BIAS_DW-1:0]        r_s1_bias;
  logic [4:0]                    r_s1_shift;
  logic signed [c_PROD_W-1:0]    w_prod    [c_NP];
  logic signed [c_PROD_W-1:0]    r_s1_prod [c_NP];

  logic                          r_s2_v, r_s2_eop, r_s2_first, r_s2_relu;
  logic [KPF*BIAS_DW-1:0]        r_s2_bias;
  logic [4:0]                    r_s2_shift;
  logic signed [ACC_WIDTH-1:0]   w_lane    [KPF];
  logic signed [ACC_WIDTH-1:0]   r_s2_sum  [KPF];

  logic signed [ACC_WIDTH-1:0]   r_acc     [KPF];
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt [KPF];
  logic                          r_s3_v, r_s3_relu;
  logic [KPF*BIAS_DW-1:0]        r_s3_bias;
  logic [4:0]                    r_s3_shift;
  logic signed [ACC_WIDTH-1:0]   r_s3_acc  [KPF];

  logic signed [c_V_W-1:0]       w_v       [KPF];
  logic [KPF*DOUT_DW-1:0]        w_rq;
  logic                          r_s4_v;
  logic [KPF*DOUT_DW-1:0]        r_s4_dout;

  logic [KPF*DOUT_DW-1:0]        r_mem     [2];
  logic                          r_wr_ptr, r_rd_ptr;
  logic [1:0]                    r_count;
  logic [1:0]                    r_inflight;

  // Outputs already committed (buffered + eop beats in the pipe) never exceed buffer depth.
  assign op_din_rdy   = r_live & ((3'(r_count) + 3'(r_inflight)) < 3'd2);
  assign w_accept     = op_din_en & op_din_rdy;
  assign blob_dout_en = (r_count != 2'd0);
  assign blob_dout    = r_mem[r_rd_ptr];
  assign w_push       = r_s4_v;
  assign w_pop        = blob_dout_en & blob_dout_rdy;

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      for (int c = 0; c < CPF; c++) begin
        w_prod[k*CPF+c] = c_PROD_W'($signed(op_din[c*DIN_DW +: DIN_DW]))
                        * c_PROD_W'($signed(op_weight[(k*CPF+c)*WW +: WW]));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      w_lane[k] = '0;
      for (int c = 0; c < CPF; c++) begin
        w_lane[k] = w_lane[k] + ACC_WIDTH'(r_s1_prod[k*CPF+c]);
      end
      w_acc_nxt[k] = r_s2_first ? r_s2_sum[k] : r_acc[k] + r_s2_sum[k];
    end
  end

  always_comb begin
    w_rq = '0;
    for (int k = 0; k < KPF; k++) begin
      w_v[k] = c_V_W'(r_s3_acc[k])
             + (c_V_W'($signed(r_s3_bias[k*BIAS_DW +: BIAS_DW])) <<< BIAS_SHL);
      if (r_s3_shift != 5'd0) begin
        w_v[k] = w_v[k] + (c_V_W'(1) << (r_s3_shift - 5'd1));
      end
      w_v[k] = w_v[k] >>> r_s3_shift;
      if (r_s3_relu && (w_v[k] < 0)) begin
        w_v[k] = '0;
      end
      if (w_v[k] > c_DOUT_MAX) begin
        w_rq[k*DOUT_DW +: DOUT_DW] = c_DOUT_MAX[DOUT_DW-1:0];
      end else if (w_v[k] < c_DOUT_MIN) begin
        w_rq[k*DOUT_DW +: DOUT_DW] = c_DOUT_MIN[DOUT_DW-1:0];
      end else begin
        w_rq[k*DOUT_DW +: DOUT_DW] = w_v[k][DOUT_DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live     <= 1'b0;
      r_first    <= 1'b1;
      r_s1_v     <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_bias  <= '0;
      r_s1_shift <= '0;
      for (int i = 0; i < c_NP; i++) r_s1_prod[i] <= '0;
    end else begin
      r_live <= 1'b1;
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_first    <= op_din_eop;
        r_s1_eop   <= op_din_eop;
        r_s1_first <= r_first;
        r_s1_relu  <= cfg_relu;
        r_s1_bias  <= op_bias;
        r_s1_shift <= cfg_shift;
        for (int i = 0; i < c_NP; i++) r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_v     <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_relu  <= 1'b0;
      r_s2_bias  <= '0;
      r_s2_shift <= '0;
      for (int k = 0; k < KPF; k++) r_s2_sum[k] <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_eop   <= r_s1_eop;
        r_s2_first <= r_s1_first;
        r_s2_relu  <= r_s1_relu;
        r_s2_bias  <= r_s1_bias;
        r_s2_shift <= r_s1_shift;
        for (int k = 0; k < KPF; k++) r_s2_sum[k] <= w_lane[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_v     <= 1'b0;
      r_s3_relu  <= 1'b0;
      r_s3_bias  <= '0;
      r_s3_shift <= '0;
      for (int k = 0; k < KPF; k++) begin
        r_acc[k]    <= '0;
        r_s3_acc[k] <= '0;
      end
    end else begin
      r_s3_v <= r_s2_v & r_s2_eop;
      if (r_s2_v) begin
        for (int k = 0; k < KPF; k++) r_acc[k] <= w_acc_nxt[k];
      end
      if (r_s2_v && r_s2_eop) begin
        r_s3_relu  <= r_s2_relu;
        r_s3_bias  <= r_s2_bias;
        r_s3_shift <= r_s2_shift;
        for (int k = 0; k < KPF; k++) r_s3_acc[k] <= w_acc_nxt[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s4_v     <= 1'b0;
      r_s4_dout  <= '0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 2'd0;
    end else begin
      r_s4_v <= r_s3_v;
      if (r_s3_v) r_s4_dout <= w_rq;
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_s4_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count    <= r_count + 2'(w_push) - 2'(w_pop);
      r_inflight <= r_inflight + 2'(w_accept & op_din_eop) - 2'(r_s4_v);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_array_v2.sv
// ============================================================================
// Module   : tb_conv_mac_array_v2
// Brief    : Directed vector table, backpressure/reset sequences and a random
//            stream checked against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_mac_array_v2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   cfg_shift;
  logic         cfg_relu;
  logic         op_din_en;
  logic         op_din_rdy;
  logic         op_din_eop;
  logic [31:0]  op_din;
  logic [255:0] op_weight;
  logic [63:0]  op_bias;
  logic         blob_dout_en;
  logic         blob_dout_rdy;
  logic [63:0]  blob_dout;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_on  = 1'b0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  conv_mac_array_v2 dut (
    .clk           (clk),
    .rst           (rst_n),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .op_din_en     (op_din_en),
    .op_din_rdy    (op_din_rdy),
    .op_din_eop    (op_din_eop),
    .op_din        (op_din),
    .op_weight     (op_weight),
    .op_bias       (op_bias),
    .blob_dout_en  (blob_dout_en),
    .blob_dout_rdy (blob_dout_rdy),
    .blob_dout     (blob_dout)
  );

  typedef struct {
    string        name;
    logic [31:0]  din;
    logic [255:0] w;
    logic [63:0]  b;
    logic [4:0]   sh;
    logic         relu;
    int           beats;
    logic [63:0]  exp;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] w_all(input logic [7:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [255:0] w_kc(input bit per_chan);
    logic [255:0] r;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 4; c++)
        r[(k*4+c)*8 +: 8] = per_chan ? 8'((k+1)*(c+1)) : 8'(k+1);
    return r;
  endfunction

  function automatic logic [7:0] rq(input longint acc, input longint bias, input int sh, input bit relu);
    longint v;
    v = acc + bias;
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic send_beat(input logic [31:0] din, input logic [255:0] w, input logic [63:0] b,
                           input logic [4:0] sh, input logic relu, input logic eop);
    int n;
    op_din = din; op_weight = w; op_bias = b; cfg_shift = sh; cfg_relu = relu;
    op_din_eop = eop; op_din_en = 1'b1;
    if (rand_on) blob_dout_rdy = ($urandom_range(0, 9) < 7);
    n = 0;
    while (!op_din_rdy && n < 100) begin
      cyc();
      if (rand_on) blob_dout_rdy = ($urandom_range(0, 9) < 7);
      n++;
    end
    if (!op_din_rdy) chk("din_rdy_timeout", 64'(op_din_rdy), 64'(1));
    cyc();
    op_din_en = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!blob_dout_en && lat < 50);
  endtask

  // Scoreboard for the random phase: compare each popped vector with the model.
  always @(negedge clk) begin
    if (rand_on && blob_dout_en && blob_dout_rdy) begin
      if (exp_q.size() == 0) begin
        chk("rand_extra_output", blob_dout, 64'hx);
      end else begin
        chk("rand_out", blob_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, got;
    bit take;
    logic [63:0] bp_exp [3];
    logic [31:0] r_din;
    logic [255:0] r_w;
    logic [63:0] r_b, e;
    logic [4:0] r_sh;
    logic r_relu;
    longint lacc [8];
    longint s;
    int len;

    rst_n = 1'b0; op_din_en = 1'b0; op_din_eop = 1'b0; op_din = '0; op_weight = '0;
    op_bias = '0; cfg_shift = '0; cfg_relu = 1'b0; blob_dout_rdy = 1'b1;

    vt[0] = '{"ones",    {8'd4, 8'd3, 8'd2, 8'd1}, w_all(8'd1), 64'd0, 5'd0, 1'b0, 1, {8{8'd10}}};
    vt[1] = '{"win25",   {4{8'd1}}, w_all(8'd1), {8{8'hFB}}, 5'd2, 1'b0, 25, {8{8'd24}}};
    vt[2] = '{"sat_pos", {4{8'd125}}, w_all(8'd2), 64'd0, 5'd0, 1'b0, 1, {8{8'h7F}}};
    vt[3] = '{"sat_neg", {4{8'h83}}, w_all(8'd2), 64'd0, 5'd0, 1'b0, 1, {8{8'h80}}};
    vt[4] = '{"relu_neg",{4{8'h83}}, w_all(8'd2), 64'd0, 5'd0, 1'b1, 1, 64'd0};
    vt[5] = '{"rnd_neg", {8'd0, 8'hFF, 8'hFF, 8'hFF}, w_all(8'd1), 64'd0, 5'd1, 1'b0, 1, {8{8'hFF}}};
    vt[6] = '{"rnd_pos", {8'd3, 8'd1, 8'd1, 8'd1}, w_all(8'd1), 64'd0, 5'd2, 1'b0, 1, {8{8'd2}}};
    vt[7] = '{"lanes",   {8'd4, 8'd3, 8'd2, 8'd1}, w_kc(1'b0),
              {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 5'd0, 1'b0, 1,
              {8'd87, 8'd76, 8'd65, 8'd54, 8'd43, 8'd32, 8'd21, 8'd10}};
    vt[8] = '{"chans",   {8'd4, 8'd3, 8'd2, 8'd1}, w_kc(1'b1), 64'd0, 5'd2, 1'b0, 1,
              {8'd60, 8'd53, 8'd45, 8'd38, 8'd30, 8'd23, 8'd15, 8'd8}};
    vt[9] = '{"relu_pos",{8'd4, 8'd3, 8'd2, 8'd1}, w_all(8'd1), 64'd0, 5'd0, 1'b1, 1, {8{8'd10}}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_rdy", 64'(op_din_rdy), 64'(0));
    chk("rst_dout_en", 64'(blob_dout_en), 64'(0));
    chk("rst_dout", blob_dout, 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("din_rdy_after_rst", 64'(op_din_rdy), 64'(1));

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < vt[i].beats; b++)
        send_beat(vt[i].din, vt[i].w, vt[i].b, vt[i].sh, vt[i].relu, b == vt[i].beats - 1);
      wait_out(lat);
      if (!blob_dout_en) chk({vt[i].name, "_timeout"}, 64'(blob_dout_en), 64'(1));
      else chk(vt[i].name, blob_dout, vt[i].exp);
      if (i == 0) chk("latency", 64'(lat), 64'(4));
    end
    repeat (2) cyc();

    // Three 1-beat windows against a stalled consumer.
    bp_exp[0] = {8{8'd4}}; bp_exp[1] = {8{8'd8}}; bp_exp[2] = {8{8'd12}};
    blob_dout_rdy = 1'b0;
    send_beat({4{8'd1}}, w_all(8'd1), 64'd0, 5'd0, 1'b0, 1'b1);
    send_beat({4{8'd2}}, w_all(8'd1), 64'd0, 5'd0, 1'b0, 1'b1);
    op_din = {4{8'd3}}; op_din_eop = 1'b1; op_din_en = 1'b1;
    repeat (8) cyc();
    chk("bp_din_rdy_low", 64'(op_din_rdy), 64'(0));
    chk("bp_held_en", 64'(blob_dout_en), 64'(1));
    chk("bp_held_dout", blob_dout, bp_exp[0]);
    blob_dout_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (blob_dout_en) begin
        if (got < 3) chk($sformatf("bp_out%0d", got), blob_dout, bp_exp[got]);
        got++;
      end
      take = op_din_en && op_din_rdy;
      cyc();
      if (take) op_din_en = 1'b0;
    end
    chk("bp_out_count", 64'(got), 64'(3));
    chk("bp_din_en_consumed", 64'(op_din_en), 64'(0));

    // Reset in the middle of a 5-beat window.
    for (int b = 0; b < 3; b++) send_beat({4{8'd10}}, w_all(8'd1), 64'd0, 5'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_din_rdy", 64'(op_din_rdy), 64'(0));
    chk("midrst_dout_en", 64'(blob_dout_en), 64'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("midrst_din_rdy_after", 64'(op_din_rdy), 64'(1));
    for (int b = 0; b < 5; b++) send_beat({4{8'd1}}, w_all(8'd1), 64'd0, 5'd0, 1'b0, b == 4);
    wait_out(lat);
    chk("midrst_window", blob_dout, {8{8'd20}});
    repeat (2) cyc();

    // Random windows, random consumer stalls, cfg/bias changing on every beat.
    rand_on = 1'b1;
    for (int wdw = 0; wdw < 30; wdw++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        r_din = $urandom();
        for (int i = 0; i < 8; i++) r_w[i*32 +: 32] = $urandom();
        r_b = {$urandom(), $urandom()};
        r_sh = 5'($urandom_range(0, 8));
        r_relu = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) begin
          s = 0;
          for (int c = 0; c < 4; c++)
            s += longint'(int'($signed(r_din[c*8 +: 8])) * int'($signed(r_w[(k*4+c)*8 +: 8])));
          lacc[k] = (b == 0) ? s : lacc[k] + s;
        end
        if (b == len - 1) begin
          for (int k = 0; k < 8; k++)
            e[k*8 +: 8] = rq(lacc[k], longint'(int'($signed(r_b[k*8 +: 8]))), int'(r_sh), r_relu);
          exp_q.push_back(e);
        end
        send_beat(r_din, r_w, r_b, r_sh, r_relu, b == len - 1);
      end
      repeat ($urandom_range(0, 2)) begin
        blob_dout_rdy = ($urandom_range(0, 9) < 7);
        cyc();
      end
    end
    lat = 0;
    while (exp_q.size() > 0 && lat < 500) begin
      blob_dout_rdy = ($urandom_range(0, 9) < 7);
      cyc();
      lat++;
    end
    chk("rand_drain", 64'(exp_q.size()), 64'(0));
    blob_dout_rdy = 1'b1;
    repeat (3) cyc();
    rand_on = 1'b0;
    chk("rand_no_extra", 64'(blob_dout_en), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
